// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle PUSH/POP/CALL/RET controller.
//
// Accepts one stack command at a time. It moves bytes between data memory and
// the stack, and writes the updated stack pointer back to the register file
// exactly once per command. The write-back happens in the FIN cycle.
//
// Every output is registered. The combinational block computes the outputs
// for the state being entered, so a strobe appears in the same cycle as the
// state that owns it.
//
// Cycle map (cycle 0 = the edge where IDLE sees Start):
//   PUSH : WR0(1) FIN(2)
//   CALL : WR0(1) WR1(2) FIN(3)
//   POP  : RD0(1) CAP(2) FIN(3)
//   RET  : RD0(1) RD1(2) CAP(3) FIN(4)
//
// Read data from memory arrives in the cycle after MemRe. RD1 therefore
// captures the byte requested by RD0, and CAP captures the byte requested by
// the previous read.
module stack_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  Clock1,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [ADDR_WIDTH-1:0] SpIn,
  input  logic [7:0]            PushData,
  input  logic [15:0]           PcIn,
  input  logic [7:0]            MemRData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemWData,
  output logic                  MemWe,
  output logic                  MemRe,
  output logic [ADDR_WIDTH-1:0] StackOut,
  output logic                  StackOutEnable,
  output logic [7:0]            PopData,
  output logic                  PopValid,
  output logic [15:0]           PcLoadValue,
  output logic                  PcLoad,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_WR1,
    S_RD0,
    S_RD1,
    S_CAP,
    S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] SP_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SP_TWO = ADDR_WIDTH'(2);

  state_t                state_q, state_d;

  // Command fields latched at acceptance; the inputs may change afterwards.
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic [7:0]            push_q, push_d;
  logic [15:0]           pc_q, pc_d;

  // High byte of the return address, held between RD1 and CAP.
  logic [7:0]            hi_q, hi_d;

  // Next values of the registered outputs.
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [7:0]            mem_wdata_d;
  logic                  mem_we_d;
  logic                  mem_re_d;
  logic [ADDR_WIDTH-1:0] stack_out_d;
  logic                  stack_out_en_d;
  logic [7:0]            pop_data_d;
  logic                  pop_valid_d;
  logic [15:0]           pc_load_value_d;
  logic                  pc_load_d;
  logic                  busy_d;
  logic                  done_d;

  // Next state, plus the output values belonging to the state being entered.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that skips an assignment would otherwise infer a latch.
    state_d         = state_q;
    op_d            = op_q;
    sp_d            = sp_q;
    push_d          = push_q;
    pc_d            = pc_q;
    hi_d            = hi_q;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    mem_we_d        = 1'b0;
    mem_re_d        = 1'b0;
    stack_out_d     = StackOut;
    stack_out_en_d  = 1'b0;
    pop_data_d      = PopData;
    pop_valid_d     = 1'b0;
    pc_load_value_d = PcLoadValue;
    pc_load_d       = 1'b0;
    done_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d   = op_t'(Op);
          sp_d   = SpIn;
          push_d = PushData;
          pc_d   = PcIn;
          if (op_d == OP_PUSH || op_d == OP_CALL) begin
            // First write lands at SP: the push byte, or the low PC byte for CALL.
            state_d     = S_WR0;
            mem_addr_d  = SpIn;
            mem_we_d    = 1'b1;
            mem_wdata_d = (op_d == OP_CALL) ? PcIn[7:0] : PushData;
          end else begin
            // The stack grows downward, so the top-of-stack byte sits at SP+1.
            state_d    = S_RD0;
            mem_addr_d = SpIn + SP_ONE;
            mem_re_d   = 1'b1;
          end
        end
      end

      S_WR0: begin
        if (op_q == OP_CALL) begin
          state_d     = S_WR1;
          mem_addr_d  = sp_q - SP_ONE;
          mem_wdata_d = pc_q[15:8];
          mem_we_d    = 1'b1;
        end else begin
          state_d = S_FIN;
        end
      end

      S_WR1: state_d = S_FIN;

      S_RD0: begin
        if (op_q == OP_RET) begin
          state_d    = S_RD1;
          mem_addr_d = sp_q + SP_TWO;
          mem_re_d   = 1'b1;
        end else begin
          state_d = S_CAP;
        end
      end

      S_RD1: begin
        // This is the byte from SP+1, which CALL left as the high PC byte.
        hi_d    = MemRData;
        state_d = S_CAP;
      end

      S_CAP: begin
        if (op_q == OP_POP) begin
          pop_data_d = MemRData;
        end else begin
          pc_load_value_d = {hi_q, MemRData};
        end
        state_d = S_FIN;
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // The pointer write-back and completion pulses all belong to FIN.
    if (state_d == S_FIN) begin
      done_d         = 1'b1;
      stack_out_en_d = 1'b1;
      case (op_q)
        OP_PUSH: stack_out_d = sp_q - SP_ONE;
        OP_CALL: stack_out_d = sp_q - SP_TWO;
        OP_POP: begin
          stack_out_d = sp_q + SP_ONE;
          pop_valid_d = 1'b1;
        end
        default: begin
          stack_out_d = sp_q + SP_TWO;
          pc_load_d   = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge Clock1) begin
    // NOTE: the latched command fields and the captured high byte are cleared
    // along with the outputs. They are only read after a fresh acceptance,
    // but clearing them keeps the post-reset state fully defined.
    if (Reset) begin
      state_q        <= S_IDLE;
      op_q           <= OP_PUSH;
      sp_q           <= '0;
      push_q         <= '0;
      pc_q           <= '0;
      hi_q           <= '0;
      MemAddr        <= '0;
      MemWData       <= '0;
      MemWe          <= 1'b0;
      MemRe          <= 1'b0;
      StackOut       <= '0;
      StackOutEnable <= 1'b0;
      PopData        <= '0;
      PopValid       <= 1'b0;
      PcLoadValue    <= '0;
      PcLoad         <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples values
      // from before this edge regardless of statement order.
      state_q        <= state_d;
      op_q           <= op_d;
      sp_q           <= sp_d;
      push_q         <= push_d;
      pc_q           <= pc_d;
      hi_q           <= hi_d;
      MemAddr        <= mem_addr_d;
      MemWData       <= mem_wdata_d;
      MemWe          <= mem_we_d;
      MemRe          <= mem_re_d;
      StackOut       <= stack_out_d;
      StackOutEnable <= stack_out_en_d;
      PopData        <= pop_data_d;
      PopValid       <= pop_valid_d;
      PcLoadValue    <= pc_load_value_d;
      PcLoad         <= pc_load_d;
      Busy           <= busy_d;
      Done           <= done_d;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer.
//
// The stimulus process issues commands and queues the expected memory
// traffic and completions. These come from a byte-array model of memory and
// plain pointer arithmetic. A negedge monitor pops and compares each queued
// item whenever the DUT shows a strobe or Done.
module tb_stack_sequencer;

  typedef enum logic [1:0] {PUSH = 2'd0, POP = 2'd1, CALL = 2'd2, RET = 2'd3} op_e;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    op_e         op;
    int          done_edge;
    logic [15:0] sp_new;
    logic [7:0]  pop_byte;
    logic [15:0] pc_val;
  } done_t;

  logic        Clock1 = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [15:0] SpIn;
  logic [7:0]  PushData;
  logic [15:0] PcIn;
  logic [7:0]  MemRData = 8'h00;
  logic [15:0] MemAddr;
  logic [7:0]  MemWData;
  logic        MemWe;
  logic        MemRe;
  logic [15:0] StackOut;
  logic        StackOutEnable;
  logic [7:0]  PopData;
  logic        PopValid;
  logic [15:0] PcLoadValue;
  logic        PcLoad;
  logic        Busy;
  logic        Done;

  always #5 Clock1 = ~Clock1;

  stack_sequencer #(.ADDR_WIDTH(16)) dut (
    .Clock1         (Clock1),
    .Reset          (Reset),
    .Start          (Start),
    .Op             (Op),
    .SpIn           (SpIn),
    .PushData       (PushData),
    .PcIn           (PcIn),
    .MemRData       (MemRData),
    .MemAddr        (MemAddr),
    .MemWData       (MemWData),
    .MemWe          (MemWe),
    .MemRe          (MemRe),
    .StackOut       (StackOut),
    .StackOutEnable (StackOutEnable),
    .PopData        (PopData),
    .PopValid       (PopValid),
    .PcLoadValue    (PcLoadValue),
    .PcLoad         (PcLoad),
    .Busy           (Busy),
    .Done           (Done)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int next_free = 0;
  bit mon_en = 1'b0;
  logic rst_prev = 1'b1;
  logic [7:0]  hold_pop = 8'h00;
  logic [15:0] hold_pc = 16'h0000;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  done_t       exp_done[$];

  logic [7:0]  tb_mem  [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        filled = 1'b0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;

  function automatic logic [7:0] seed_byte(input int a);
    return 8'(a * 37) ^ 8'(a >>> 8) ^ 8'hA3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  always @(posedge Clock1) begin
    edge_cnt <= edge_cnt + 1;
    rst_prev <= Reset;
  end

  // Memory seen by the DUT: read data is returned one cycle after MemRe.
  always @(posedge Clock1) begin
    if (!filled) begin
      for (int i = 0; i < 65536; i++) tb_mem[i] <= seed_byte(i);
      filled <= 1'b1;
    end
    if (MemWe) tb_mem[MemAddr] <= MemWData;
    if (pre_we) tb_mem[pre_addr] <= pre_data;
    if (MemRe) MemRData <= tb_mem[MemAddr];
  end

  // Monitor: compare each strobe and completion against the queued expectations.
  always @(negedge Clock1) begin : monitor
    wr_t w;
    logic [15:0] ra;
    done_t d;
    if (rst_prev) begin
      hold_pop = 8'h00;
      hold_pc  = 16'h0000;
    end
    if (mon_en) begin
      check("busy", {31'b0, Busy}, {31'b0, (edge_cnt >= busy_lo && edge_cnt <= busy_hi)});
      check("soe_eq_done", {31'b0, StackOutEnable}, {31'b0, Done});
      check("we_re_exclusive", {31'b0, MemWe & MemRe}, 0);
      if (MemWe) begin
        check("write_expected", {31'b0, exp_wr.size() > 0}, 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", {16'b0, MemAddr}, {16'b0, w.addr});
          check("wr_data", {24'b0, MemWData}, {24'b0, w.data});
        end
      end
      if (MemRe) begin
        check("read_expected", {31'b0, exp_rd.size() > 0}, 1);
        if (exp_rd.size() > 0) begin
          ra = exp_rd.pop_front();
          check("rd_addr", {16'b0, MemAddr}, {16'b0, ra});
        end
      end
      if (Done) begin
        check("done_expected", {31'b0, exp_done.size() > 0}, 1);
        check("no_strobe_in_fin", {31'b0, MemWe | MemRe}, 0);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          check("done_cycle", edge_cnt, d.done_edge);
          check("stack_out", {16'b0, StackOut}, {16'b0, d.sp_new});
          check("pop_valid", {31'b0, PopValid}, {31'b0, d.op == POP});
          check("pc_load", {31'b0, PcLoad}, {31'b0, d.op == RET});
          if (d.op == POP) hold_pop = d.pop_byte;
          if (d.op == RET) hold_pc = d.pc_val;
        end
      end else begin
        check("no_stray_pulse", {31'b0, PopValid | PcLoad}, 0);
      end
      check("pop_data", {24'b0, PopData}, {24'b0, hold_pop});
      check("pc_load_value", {16'b0, PcLoadValue}, {16'b0, hold_pc});
    end
  end

  task automatic scramble();
    Op       = 2'($urandom_range(0, 3));
    SpIn     = 16'($urandom);
    PushData = 8'($urandom);
    PcIn     = 16'($urandom);
  endtask

  // Issue one command at the first edge where the DUT is free. With junk set,
  // Start is held high with random operands while waiting and after acceptance.
  task automatic issue(input op_e op, input logic [15:0] sp, input logic [7:0] data,
                       input logic [15:0] pc, input bit junk, input bit abort);
    int e;
    int lat;
    done_t d;
    wr_t w;
    logic [15:0] a1;
    logic [15:0] a2;
    while (edge_cnt + 1 < next_free) begin
      Start = junk;
      if (junk) scramble();
      @(negedge Clock1);
    end
    Start    = 1'b1;
    Op       = op;
    SpIn     = sp;
    PushData = data;
    PcIn     = pc;
    e  = edge_cnt + 1;
    a1 = sp + 16'd1;
    a2 = sp + 16'd2;
    d.op = op;
    d.pop_byte = 8'h00;
    d.pc_val = 16'h0000;
    case (op)
      PUSH: begin
        lat = 2;
        w.addr = sp; w.data = data; exp_wr.push_back(w);
        ref_mem[sp] = data;
        d.sp_new = sp - 16'd1;
      end
      CALL: begin
        lat = 3;
        w.addr = sp; w.data = pc[7:0]; exp_wr.push_back(w);
        ref_mem[sp] = pc[7:0];
        w.addr = sp - 16'd1; w.data = pc[15:8]; exp_wr.push_back(w);
        ref_mem[w.addr] = pc[15:8];
        d.sp_new = sp - 16'd2;
      end
      POP: begin
        lat = 3;
        exp_rd.push_back(a1);
        d.pop_byte = ref_mem[a1];
        d.sp_new = a1;
      end
      default: begin
        lat = 4;
        exp_rd.push_back(a1);
        exp_rd.push_back(a2);
        d.pc_val = {ref_mem[a1], ref_mem[a2]};
        d.sp_new = a2;
      end
    endcase
    d.done_edge = e + lat - 1;
    busy_lo = e;
    if (abort) begin
      busy_hi   = e + 1;
      next_free = e + 3;
    end else begin
      busy_hi   = e + lat - 1;
      next_free = e + lat + 1;
      exp_done.push_back(d);
    end
    @(negedge Clock1);
    Start = junk;
    scramble();
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = v;
    ref_mem[a] = v;
    @(negedge Clock1);
    pre_we = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {31'b0, |{MemAddr, MemWData, MemWe, MemRe, StackOut, StackOutEnable,
                           PopData, PopValid, PcLoadValue, PcLoad, Busy, Done}}, 0);
  endtask

  initial begin : stimulus
    op_e op;
    logic [15:0] sp;
    bit junk;
    int guard;
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(i);
    Reset = 1'b1;
    Start = 1'b0;
    Op = 2'd0; SpIn = 16'h0; PushData = 8'h0; PcIn = 16'h0;
    repeat (3) @(negedge Clock1);
    check_all_zero("reset_outputs");
    Reset = 1'b0;
    mon_en = 1'b1;
    next_free = edge_cnt + 1;

    // Directed sequences from the command descriptions.
    issue(PUSH, 16'h00FF, 8'hA5, 16'h0000, 1'b0, 1'b0);
    issue(CALL, 16'h0100, 8'h00, 16'h1234, 1'b0, 1'b0);
    issue(RET,  16'h00FE, 8'h00, 16'h0000, 1'b0, 1'b0);
    preload(16'h0000, 8'h5A);
    issue(POP,  16'hFFFF, 8'h00, 16'h0000, 1'b0, 1'b0);
    issue(PUSH, 16'h0000, 8'h3C, 16'h0000, 1'b0, 1'b0);
    issue(CALL, 16'h0000, 8'h00, 16'h8765, 1'b0, 1'b0);

    // Start held high through a CALL: only the accepted commands may complete.
    issue(CALL, 16'h0300, 8'h00, 16'hABCD, 1'b1, 1'b0);
    issue(PUSH, 16'h02FE, 8'h77, 16'h0000, 1'b1, 1'b0);
    issue(POP,  16'h02FD, 8'h00, 16'h0000, 1'b0, 1'b0);

    // Reset during WR1 of a CALL: both writes land, no completion follows.
    issue(CALL, 16'h0200, 8'h00, 16'hBEEF, 1'b0, 1'b1);
    @(negedge Clock1);
    Reset = 1'b1;
    @(negedge Clock1);
    check_all_zero("abort_outputs");
    Reset = 1'b0;
    issue(PUSH, 16'h0200, 8'h99, 16'h0000, 1'b0, 1'b0);
    issue(POP,  16'h01FF, 8'h00, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic around the pointer wrap and a small shared window.
    for (int n = 0; n < 300; n++) begin
      op = op_e'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       sp = 16'h0000;
        1:       sp = 16'hFFFF;
        2:       sp = 16'hFFFE;
        3:       sp = 16'h0001;
        default: sp = 16'h00F0 + 16'($urandom_range(0, 31));
      endcase
      junk = ($urandom_range(0, 3) == 0);
      issue(op, sp, 8'($urandom), 16'($urandom), junk, 1'b0);
      if (!junk && $urandom_range(0, 2) == 0) begin
        Start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge Clock1);
      end
    end
    Start = 1'b0;

    guard = 0;
    while (exp_done.size() != 0 && guard < 200) begin
      @(negedge Clock1);
      guard++;
    end
    repeat (3) @(negedge Clock1);
    check("done_queue_drained", exp_done.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller for PUSH, POP, CALL and RET in the 8-bit core. Sits beside the register file: it takes the 16-bit stack pointer read from the SH:SL pair, moves bytes between the stack and data memory, and writes the updated pointer back through the register file's stack write port (StackIn/StackInEnable). It also returns popped bytes for register writeback and the return address for the PC.

## Interface
- Parameters:
- `ADDR_WIDTH`, 16: data-memory address and stack-pointer width.
- Ports:
- `Clock1` input 1: sole clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `Start` input 1: command request, sampled only while Busy=0.
- `Op` input 2: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- `SpIn` input 16: current stack pointer {SH,SL}.
- `PushData` input 8: byte to push.
- `PcIn` input 16: return address for CALL.
- `MemRData` input 8: memory read data, valid the cycle after MemRe.
- `MemAddr` output 16: memory address.
- `MemWData` output 8: memory write data.
- `MemWe` output 1: memory write strobe.
- `MemRe` output 1: memory read strobe.
- `StackOut` output 16: new stack pointer, drives register file StackIn.
- `StackOutEnable` output 1: one-cycle pulse, drives StackInEnable.
- `PopData` output 8: popped byte.
- `PopValid` output 1: one-cycle pulse, PopData valid.
- `PcLoadValue` output 16: return address from RET.
- `PcLoad` output 1: one-cycle pulse, PcLoadValue valid.
- `Busy` output 1: command in progress.
- `Done` output 1: one-cycle completion pulse.

## Operation
- All outputs are registered. On reset every output is 0 and the FSM returns to IDLE.
- FSM states: IDLE, WR0, WR1, RD0, RD1, CAP, FIN.
- IDLE accepts a command on Start=1. It latches Op, SpIn (as SP), PushData and PcIn.
  - PUSH and CALL go to WR0.
  - POP and RET go to RD0.
- WR0: MemAddr=SP, MemWe=1.
  - PUSH writes PushData, then goes to FIN.
  - CALL writes PcIn[7:0], then goes to WR1.
- WR1 (CALL only): MemAddr=SP-1, MemWData=PcIn[15:8], MemWe=1, then FIN.
- RD0: MemAddr=SP+1, MemRe=1.
  - POP goes to CAP.
  - RET goes to RD1.
- RD1 (RET only): captures MemRData as high byte; MemAddr=SP+2, MemRe=1; then CAP.
- CAP: captures MemRData.
  - For POP, this is the pop byte.
  - For RET, this is the low byte.
  - Then FIN.
- FIN: Done=1 and StackOutEnable=1.
  - PUSH: StackOut=SP-1.
  - CALL: StackOut=SP-2.
  - POP: StackOut=SP+1, PopValid=1.
  - RET: StackOut=SP+2, PcLoad=1, PcLoadValue={high,low}.
  - Then IDLE.
- Pointer arithmetic is modulo 2^16:
  - PUSH at SP=0x0000 writes 0x0000 and leaves SP=0xFFFF.
  - CALL at 0x0000 writes 0x0000 and 0xFFFF.
  - POP at 0xFFFF reads 0x0000.
- The stack pointer is written back exactly once per command, in FIN. Memory strobes are never active in FIN or IDLE.
- StackInEnable has priority over general register writes in the register file. Core control must not schedule a RegEnable write in the FIN cycle.

## Timing
- Start is accepted in cycle 0 (edge where IDLE sees Start=1). Busy=1 from cycle 1 through FIN inclusive.
- Done lands in FIN:
  - PUSH: cycle 2.
  - CALL: cycle 3.
  - POP: cycle 3.
  - RET: cycle 4.
- Busy=0 and IDLE again in the cycle after FIN. A new Start can be accepted there, giving one cycle of turnaround.
- Start while Busy=1 is ignored, with no queueing. Op, SpIn, PushData and PcIn may change freely after acceptance.
- Pulses last exactly one cycle: Done, StackOutEnable, PopValid, PcLoad, MemWe, MemRe. PopData and PcLoadValue hold until the next capture.
- Reset asserted mid-command returns to IDLE on that edge with all outputs 0.
  - No StackOutEnable, Done or PcLoad is issued for the aborted command.
  - Memory writes already issued are not undone.
- Reset has priority over Start in the same cycle.

## Test plan
- PUSH with SpIn=0x00FF, PushData=0xA5 -> cycle 1: MemWe, addr 0x00FF, data 0xA5; cycle 2: StackOut=0x00FE, StackOutEnable=1, Done=1.
- CALL with SpIn=0x0100, PcIn=0x1234 -> writes 0x34 @0x0100, then 0x12 @0x00FF; cycle 3: StackOut=0x00FE, Done.
- RET following the CALL above, with SpIn=0x00FE and memory model returning the stored bytes -> reads 0x00FF then 0x0100; cycle 4: PcLoad=1, PcLoadValue=0x1234, StackOut=0x0100.
- POP with SpIn=0xFFFF, mem[0x0000]=0x5A -> MemRe addr 0x0000; cycle 3: PopData=0x5A, PopValid=1, StackOut=0x0000. Also PUSH at SpIn=0x0000 -> StackOut=0xFFFF.
- Start pulsed every cycle during a CALL -> only the first command runs. The next Start is accepted in the cycle after Done, with exactly one Done per accepted command.
- Reset asserted in the WR1 cycle of a CALL -> next cycle all outputs 0, IDLE, no StackOutEnable or Done. A following PUSH completes normally.
